// File: rtl/mips_mem_arbiter.sv
// Arbiter sharing one single-ported, variable-latency memory between instruction fetch (I)
// and data access (D). Define MEM_ARB_FAIR_EN to bound consecutive D grants while I waits.
module mips_mem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int TIMEOUT      = 16,
    parameter int MAX_D_STREAK = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          acc_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          stall_if,
    output logic          stall_mem
);
    localparam int          CW     = $clog2(TIMEOUT);
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_D_ACC = 2'd1,
        S_I_ACC = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          i_done_q, i_done_d;
    logic          d_done_q, d_done_d;
    logic          acc_err_q, acc_err_d;
    logic [CW-1:0] tcnt_q, tcnt_d;

    logic i_elig, d_elig, can_grant, grant_d, grant_i, i_first;

    // The done cycle is a turnaround: nothing is granted while either done pulses.
    assign i_elig    = i_req & ~i_done_q;
    assign d_elig    = d_req & ~d_done_q;
    assign can_grant = (state_q == S_IDLE) & ~i_done_q & ~d_done_q;
    assign grant_d   = can_grant & d_elig & ~i_first;
    assign grant_i   = can_grant & i_elig & ~grant_d;

`ifdef MEM_ARB_FAIR_EN
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    logic [SW-1:0] streak_q, streak_d;

    always_comb begin
        streak_d = streak_q;
        if (!i_req || grant_i) begin
            streak_d = '0;
        end else if (grant_d && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    assign i_first = i_elig & (streak_q == STREAK_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    logic unused_max_d_streak;
    assign unused_max_d_streak = (MAX_D_STREAK != 0);
    assign i_first = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        acc_err_d   = 1'b0;
        tcnt_d      = tcnt_q;

        case (state_q)
            S_IDLE: begin
                if (grant_d) begin
                    state_d     = S_D_ACC;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    tcnt_d      = '0;
                end else if (grant_i) begin
                    state_d     = S_I_ACC;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = '0;
                    tcnt_d      = '0;
                end
            end
            S_D_ACC, S_I_ACC: begin
                // A ready on the expiry edge still counts as a normal completion.
                if (mem_ready || (tcnt_q == T_LAST)) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    acc_err_d = ~mem_ready;
                    if (state_q == S_D_ACC) begin
                        d_done_d = 1'b1;
                        if (!mem_ready) begin
                            d_rdata_d = '0;
                        end else if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end else begin
                        i_done_d  = 1'b1;
                        i_rdata_d = mem_ready ? mem_rdata : '0;
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            acc_err_q   <= 1'b0;
            tcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            acc_err_q   <= acc_err_d;
            tcnt_q      <= tcnt_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign acc_err   = acc_err_q;
    assign stall_if  = i_req & ~i_done_q;
    assign stall_mem = d_req & ~d_done_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: reset, fetch, wait states, timeout, priority,
// mid-access reset and D-streak behaviour (follows MEM_ARB_FAIR_EN when defined).
module tb_mips_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        acc_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        stall_if;
    logic        stall_mem;

    int checks = 0;
    int errors = 0;

    mips_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(16), .MAX_D_STREAK(4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .acc_err(acc_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge (start of the next cycle).
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) nxt();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %0h exp 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %0h exp 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata got %h exp 0", mem_wdata); end
        checks++; if ({i_done, d_done, acc_err} !== 3'b000) begin errors++; $display("FAIL rst_done_err got %b exp 000", {i_done, d_done, acc_err}); end
        checks++; if (i_rdata !== 32'h0) begin errors++; $display("FAIL rst_i_rdata got %h exp 0", i_rdata); end
        checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL rst_d_rdata got %h exp 0", d_rdata); end
        reset = 1'b1;
        nxt();
        $display("reset released");
    endtask

    task automatic test_fetch();
        nxt(); i_req = 1'b1; i_addr = 32'h0000_0040; mem_ready = 1'b0; #1;   // cycle 0
        checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL fetch_stall_c0 got %0h exp 1", stall_if); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fetch_mem_req_c0 got %0h exp 0", mem_req); end
        nxt(); mem_ready = 1'b1; mem_rdata = 32'h2010_0005; #1;                // cycle 1
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL fetch_mem_req_c1 got %0h exp 1", mem_req); end
        checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL fetch_mem_addr got %h exp 40", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL fetch_mem_we got %0h exp 0", mem_we); end
        checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL fetch_stall_c1 got %0h exp 1", stall_if); end
        checks++; if (i_done !== 1'b0) begin errors++; $display("FAIL fetch_early_done got %0h exp 0", i_done); end
        nxt(); mem_ready = 1'b0; #1;                                            // cycle 2
        checks++; if (i_done !== 1'b1) begin errors++; $display("FAIL fetch_i_done got %0h exp 1", i_done); end
        checks++; if (i_rdata !== 32'h2010_0005) begin errors++; $display("FAIL fetch_i_rdata got %h exp 20100005", i_rdata); end
        checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL fetch_stall_c2 got %0h exp 0", stall_if); end
        checks++; if ({mem_req, acc_err} !== 2'b00) begin errors++; $display("FAIL fetch_req_err_c2 got %b exp 00", {mem_req, acc_err}); end
        nxt(); i_req = 1'b0; #1;                                                // cycle 3
        checks++; if ({mem_req, i_done} !== 2'b00) begin errors++; $display("FAIL fetch_no_regrant got %b exp 00", {mem_req, i_done}); end
        $display("fetch addr=%h rdata=%h", 32'h40, i_rdata);
    endtask

    task automatic test_wait();
        nxt(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; #1;                // cycle 0
        for (int k = 1; k <= 4; k++) begin
            nxt();
            if (k == 4) begin mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D; end
            #1;
            checks++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h200}) begin errors++; $display("FAIL wait_stable_c%0d got req=%0h we=%0h addr=%h exp 1 0 200", k, mem_req, mem_we, mem_addr); end
            checks++; if ({d_done, stall_mem} !== 2'b01) begin errors++; $display("FAIL wait_done_c%0d got done=%0h stall=%0h exp 0 1", k, d_done, stall_mem); end
        end
        nxt(); mem_ready = 1'b0; #1;                                            // cycle 5
        checks++; if ({d_done, acc_err} !== 2'b10) begin errors++; $display("FAIL wait_done_c5 got done=%0h err=%0h exp 1 0", d_done, acc_err); end
        checks++; if (d_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL wait_d_rdata got %h exp cafef00d", d_rdata); end
        nxt(); d_req = 1'b0;
        nxt();
        $display("load addr=%h rdata=%h after 3 wait cycles", 32'h200, d_rdata);
    endtask

    task automatic test_timeout();
        for (int pass = 0; pass < 2; pass++) begin
            nxt(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100 + 32'(pass * 4); mem_ready = 1'b0; #1;
            for (int k = 1; k <= 16; k++) begin
                nxt();
                if (pass == 1 && k == 16) begin mem_ready = 1'b1; mem_rdata = 32'h0000_BEEF; end
                #1;
                checks++; if ({mem_req, d_done} !== 2'b10) begin errors++; $display("FAIL tmo%0d_c%0d got req=%0h done=%0h exp 1 0", pass, k, mem_req, d_done); end
            end
            nxt(); mem_ready = 1'b0; #1;                                        // cycle 17
            checks++; if ({mem_req, d_done} !== 2'b01) begin errors++; $display("FAIL tmo%0d_end got req=%0h done=%0h exp 0 1", pass, mem_req, d_done); end
            checks++; if (acc_err !== (pass == 0)) begin errors++; $display("FAIL tmo%0d_acc_err got %0h exp %0h", pass, acc_err, pass == 0); end
            checks++; if (d_rdata !== ((pass == 0) ? 32'h0 : 32'h0000_BEEF)) begin errors++; $display("FAIL tmo%0d_d_rdata got %h exp %h", pass, d_rdata, (pass == 0) ? 32'h0 : 32'h0000_BEEF); end
            $display("timeout pass %0d: acc_err=%0h d_rdata=%h", pass, acc_err, d_rdata);
            nxt(); d_req = 1'b0;
            nxt();
        end
    endtask

    task automatic test_priority();
        nxt();                                                                  // cycle 0
        i_req = 1'b1; i_addr = 32'h80;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h54; d_wdata = 32'h7;
        nxt(); mem_ready = 1'b1; #1;                                            // cycle 1
        checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h54, 32'h7}) begin errors++; $display("FAIL prio_store got req=%0h we=%0h addr=%h wdata=%h exp 1 1 54 7", mem_req, mem_we, mem_addr, mem_wdata); end
        nxt(); mem_ready = 1'b0; #1;                                            // cycle 2
        checks++; if ({d_done, i_done, mem_req} !== 3'b100) begin errors++; $display("FAIL prio_d_done got d=%0h i=%0h req=%0h exp 1 0 0", d_done, i_done, mem_req); end
        checks++; if (d_rdata !== 32'h0000_BEEF) begin errors++; $display("FAIL prio_store_rdata got %h exp 0000beef", d_rdata); end
        nxt(); d_req = 1'b0; #1;                                                // cycle 3
        checks++; if ({mem_req, stall_if} !== 2'b01) begin errors++; $display("FAIL prio_turnaround got req=%0h stall_if=%0h exp 0 1", mem_req, stall_if); end
        nxt(); mem_ready = 1'b1; mem_rdata = 32'h0000_1234; #1;                 // cycle 4
        checks++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h80}) begin errors++; $display("FAIL prio_fetch got req=%0h we=%0h addr=%h exp 1 0 80", mem_req, mem_we, mem_addr); end
        nxt(); mem_ready = 1'b0; #1;                                            // cycle 5
        checks++; if ({i_done, i_rdata} !== {1'b1, 32'h0000_1234}) begin errors++; $display("FAIL prio_i_done got done=%0h rdata=%h exp 1 00001234", i_done, i_rdata); end
        nxt(); i_req = 1'b0;
        nxt();
        $display("store 54<=7 then fetch 80 -> %h", i_rdata);
    endtask

    task automatic test_reset_mid();
        nxt(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; #1;                // cycle 0
        nxt(); #1;                                                              // cycle 1
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmid_mem_req got %0h exp 1", mem_req); end
        nxt(); reset = 1'b0; #1;                                                // cycle 2, mid-access
        checks++; if ({mem_req, d_done, i_done} !== 3'b000) begin errors++; $display("FAIL rmid_async got req=%0h d=%0h i=%0h exp 0 0 0", mem_req, d_done, i_done); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rmid_addr got %h exp 0", mem_addr); end
        d_req = 1'b0;
        nxt(); nxt(); reset = 1'b1;
        nxt(); #1;
        checks++; if ({mem_req, d_done} !== 2'b00) begin errors++; $display("FAIL rmid_after got req=%0h done=%0h exp 0 0", mem_req, d_done); end
        $display("reset mid-access dropped request");
    endtask

    task automatic test_fairness();
        int nd = 0;
        int first_i = -1;
        int d_at_i = -1;
        logic prev_d = 1'b0;
        logic prev_i = 1'b0;
        for (int c = 0; c < 30; c++) begin
            nxt();
            if (c == 0) begin
                d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000;
                i_req = 1'b1; i_addr = 32'h2000;
            end
            if (prev_d) d_addr = d_addr + 32'h4;
            if (prev_i) i_addr = i_addr + 32'h4;
            if (d_done) begin nd++; $display("c%0d d_done #%0d", c, nd); end
            if (i_done) begin
                $display("c%0d i_done", c);
                if (first_i < 0) begin first_i = c; d_at_i = nd; end
            end
            prev_d = d_done;
            prev_i = i_done;
            mem_ready = mem_req;
            mem_rdata = 32'(c);
        end
`ifdef MEM_ARB_FAIR_EN
        checks++; if (d_at_i !== 4) begin errors++; $display("FAIL fair_d_before_i got %0d exp 4", d_at_i); end
        checks++; if (first_i !== 14) begin errors++; $display("FAIL fair_i_cycle got %0d exp 14", first_i); end
`else
        checks++; if (first_i !== -1) begin errors++; $display("FAIL strict_i_granted got cycle %0d exp none", first_i); end
        checks++; if (nd !== 10) begin errors++; $display("FAIL strict_d_count got %0d exp 10", nd); end
`endif
        d_req = 1'b0; i_req = 1'b0;
        repeat (3) begin nxt(); mem_ready = mem_req; end
        mem_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch();
        test_wait();
        test_timeout();
        test_priority();
        test_reset_mid();
        test_fairness();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
